// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, hex font and blanking helper for the seven-segment scanner
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // Active-high segment patterns {g,f,e,d,c,b,a} for hex digits 0..F
    localparam seg_t FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Bit k set when nibble k and every higher nibble are zero; digit 0 is never blanked
    function automatic logic [3:0] lz_blank_mask(input logic [15:0] v);
        lz_blank_mask = {v[15:12] == 4'h0, v[15:8] == 8'h00, v[15:4] == 12'h000, 1'b0};
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational hex nibble to active-high segment pattern
module hex_to_seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = FONT[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - 4-digit multiplexed hex display driver with dead time,
// leading-zero blanking and a once-per-frame input snapshot
module seven_seg_scanner
    import seg7_pkg::*;
#(
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 500,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic        blank_lz,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] DEAD = PW'(DEAD_CYCLES);
    localparam logic          POL  = (ACTIVE_LOW != 0);

    logic [PW-1:0] presc;
    logic [1:0]    digit;
    logic [15:0]   shadow_val;
    logic [3:0]    shadow_dp;

    logic [3:0] nib;
    seg_t       font_seg;
    logic [3:0] lz_mask;
    logic       active;
    logic       blank;
    logic [3:0] an_h;
    seg_t       seg_h;
    logic       dp_h;

    assign nib     = shadow_val[{digit, 2'b00} +: 4];
    assign lz_mask = lz_blank_mask(shadow_val);

    hex_to_seg u_font (
        .nibble (nib),
        .seg    (font_seg)
    );

    // Blanked digits keep their anode lit so the decimal point still shows
    always_comb begin
        active = (presc >= DEAD);
        blank  = blank_lz && lz_mask[digit];
        an_h   = active ? (4'b0001 << digit) : 4'b0000;
        seg_h  = (active && !blank) ? font_seg : 7'h00;
        dp_h   = active && shadow_dp[digit];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            digit      <= 2'd0;
            shadow_val <= 16'h0000;
            shadow_dp  <= 4'h0;
            anode      <= {4{POL}};
            seg        <= {7{POL}};
            dp         <= POL;
            frame_done <= 1'b0;
        end else begin
            if (presc == LAST) begin
                presc <= '0;
                digit <= digit + 2'd1;
            end else begin
                presc <= presc + 1'b1;
            end
            if (presc == '0 && digit == 2'd0) begin
                shadow_val <= value_in;
                shadow_dp  <= dp_mask;
            end
            anode      <= an_h ^ {4{POL}};
            seg        <= seg_h ^ {7{POL}};
            dp         <= dp_h ^ POL;
            frame_done <= (presc == LAST) && (digit == 2'd3);
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - self-checking bench for seven_seg_scanner
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic        blank_lz;
    logic [3:0]  dp_mask;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int passes = 0;

    seven_seg_scanner #(
        .CLK_DIV     (8),
        .DEAD_CYCLES (2),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .blank_lz   (blank_lz),
        .dp_mask    (dp_mask),
        .anode      (anode),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dpm;
        logic        blz;
        int          slot;
        logic [3:0]  an;
        logic [6:0]  sg;
        logic        d;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds reset for 3 edges; the next edge after return is the first scanning edge
    task automatic do_reset(input logic [15:0] v, input logic [3:0] dpm, input logic blz);
        rst      = 1'b1;
        value_in = v;
        dp_mask  = dpm;
        blank_lz = blz;
        tick(3);
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        int bad;
        int deads;

        rst = 1'b1; value_in = 16'h0; blank_lz = 1'b0; dp_mask = 4'h0;

        // Output after edge n shows slot (n-1)/8, active once (n-1)%8 >= 2
        vecs.push_back('{16'h1234, 4'h0, 1'b0, 0, 4'hE, 7'h19, 1'b1});
        vecs.push_back('{16'h1234, 4'h0, 1'b0, 1, 4'hD, 7'h30, 1'b1});
        vecs.push_back('{16'h1234, 4'h0, 1'b0, 2, 4'hB, 7'h24, 1'b1});
        vecs.push_back('{16'h1234, 4'h0, 1'b0, 3, 4'h7, 7'h79, 1'b1});
        vecs.push_back('{16'h6789, 4'h0, 1'b0, 0, 4'hE, 7'h10, 1'b1});
        vecs.push_back('{16'h6789, 4'h0, 1'b0, 1, 4'hD, 7'h00, 1'b1});
        vecs.push_back('{16'h6789, 4'h0, 1'b0, 2, 4'hB, 7'h78, 1'b1});
        vecs.push_back('{16'h6789, 4'h0, 1'b0, 3, 4'h7, 7'h02, 1'b1});
        vecs.push_back('{16'hFEDC, 4'h0, 1'b0, 0, 4'hE, 7'h46, 1'b1});
        vecs.push_back('{16'hFEDC, 4'h0, 1'b0, 1, 4'hD, 7'h21, 1'b1});
        vecs.push_back('{16'hFEDC, 4'h0, 1'b0, 2, 4'hB, 7'h06, 1'b1});
        vecs.push_back('{16'hFEDC, 4'h0, 1'b0, 3, 4'h7, 7'h0E, 1'b1});
        vecs.push_back('{16'h00A5, 4'h0, 1'b1, 0, 4'hE, 7'h12, 1'b1});
        vecs.push_back('{16'h00A5, 4'h0, 1'b1, 1, 4'hD, 7'h08, 1'b1});
        vecs.push_back('{16'h00A5, 4'h0, 1'b1, 2, 4'hB, 7'h7F, 1'b1});
        vecs.push_back('{16'h00A5, 4'h0, 1'b1, 3, 4'h7, 7'h7F, 1'b1});
        vecs.push_back('{16'h0000, 4'h0, 1'b1, 0, 4'hE, 7'h40, 1'b1});
        vecs.push_back('{16'h0000, 4'h0, 1'b1, 1, 4'hD, 7'h7F, 1'b1});
        vecs.push_back('{16'h0000, 4'h0, 1'b1, 3, 4'h7, 7'h7F, 1'b1});
        vecs.push_back('{16'h0000, 4'h0, 1'b0, 3, 4'h7, 7'h40, 1'b1});
        vecs.push_back('{16'h0100, 4'h0, 1'b1, 0, 4'hE, 7'h40, 1'b1});
        vecs.push_back('{16'h0100, 4'h0, 1'b1, 1, 4'hD, 7'h40, 1'b1});
        vecs.push_back('{16'h0100, 4'h0, 1'b1, 2, 4'hB, 7'h79, 1'b1});
        vecs.push_back('{16'h0100, 4'h0, 1'b1, 3, 4'h7, 7'h7F, 1'b1});
        vecs.push_back('{16'h8888, 4'h5, 1'b0, 0, 4'hE, 7'h00, 1'b0});
        vecs.push_back('{16'h8888, 4'h5, 1'b0, 1, 4'hD, 7'h00, 1'b1});
        vecs.push_back('{16'h8888, 4'h5, 1'b0, 2, 4'hB, 7'h00, 1'b0});
        vecs.push_back('{16'h8888, 4'h5, 1'b0, 3, 4'h7, 7'h00, 1'b1});
        vecs.push_back('{16'h00A5, 4'h8, 1'b1, 3, 4'h7, 7'h7F, 1'b0});

        // Reset state and first-digit latency
        rst = 1'b1; value_in = 16'h1234;
        tick(3);
        chk("rst_anode", 32'(anode), 32'h0F);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_fd", 32'(frame_done), 32'h0);
        rst = 1'b0;
        tick(2);
        chk("first_dead", 32'(anode), 32'h0F);
        tick(1);
        chk("first_anode", 32'(anode), 32'h0E);
        chk("first_seg", 32'(seg), 32'h19);

        foreach (vecs[i]) begin
            do_reset(vecs[i].val, vecs[i].dpm, vecs[i].blz);
            tick(8 * vecs[i].slot + 2);
            chk($sformatf("v%0d_dead_an", i), 32'(anode), 32'h0F);
            chk($sformatf("v%0d_dead_seg", i), 32'(seg), 32'h7F);
            tick(1);
            chk($sformatf("v%0d_an", i), 32'(anode), 32'(vecs[i].an));
            chk($sformatf("v%0d_seg", i), 32'(seg), 32'(vecs[i].sg));
            chk($sformatf("v%0d_dp", i), 32'(dp), 32'(vecs[i].d));
        end

        // frame_done period and dead-cycle count over two frames
        do_reset(16'h1234, 4'h0, 1'b0);
        pulses = 0; bad = 0; deads = 0;
        for (int n = 1; n <= 64; n++) begin
            tick(1);
            if (frame_done) begin
                pulses++;
                if (n % 32 != 0) bad++;
            end
            if (anode == 4'hF) deads++;
        end
        chk("fd_count", 32'(pulses), 32'd2);
        chk("fd_position", 32'(bad), 32'd0);
        chk("dead_cycles", 32'(deads), 32'd16);

        // Input change mid-frame must not tear the current frame
        do_reset(16'h1234, 4'h0, 1'b0);
        tick(20);
        value_in = 16'hABCD;
        tick(7);
        chk("tear_d3_an", 32'(anode), 32'h07);
        chk("tear_d3_seg", 32'(seg), 32'h79);
        tick(8);
        chk("tear_n0_seg", 32'(seg), 32'h21);
        tick(8);
        chk("tear_n1_seg", 32'(seg), 32'h46);
        tick(8);
        chk("tear_n2_seg", 32'(seg), 32'h03);
        tick(8);
        chk("tear_n3_an", 32'(anode), 32'h07);
        chk("tear_n3_seg", 32'(seg), 32'h08);

        // Reset in the digit-2 slot at presc=5 aborts the frame
        do_reset(16'h1234, 4'h0, 1'b0);
        tick(21);
        rst = 1'b1;
        value_in = 16'h5A5A;
        tick(1);
        chk("mid_rst_anode", 32'(anode), 32'h0F);
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        chk("mid_rst_fd", 32'(frame_done), 32'h0);
        tick(1);
        rst = 1'b0;
        pulses = 0;
        for (int n = 1; n <= 31; n++) begin
            tick(1);
            if (n == 3) begin
                chk("restart_anode", 32'(anode), 32'h0E);
                chk("restart_seg", 32'(seg), 32'h08);
            end
            if (frame_done) pulses++;
        end
        chk("restart_no_fd", 32'(pulses), 32'd0);
        tick(1);
        chk("restart_fd", 32'(frame_done), 32'h1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
